// File: rtl/lvds_panel_seq_pkg.sv
// Shared state encoding, LP171WU3 default timing and the state-to-rail decode
// for the LVDS panel power sequencer.
package lvds_panel_seq_pkg;

    typedef enum logic [2:0] {
        ST_OFF_WAIT  = 3'd0,
        ST_OFF       = 3'd1,
        ST_VDD_UP    = 3'd2,
        ST_LVDS_UP   = 3'd3,
        ST_ON        = 3'd4,
        ST_BL_DOWN   = 3'd5,
        ST_LVDS_DOWN = 3'd6
    } seq_state_t;

    // LP171WU3 defaults, in system clock cycles
    localparam int DEF_T_VDD_LVDS = 1_000_000;
    localparam int DEF_BL_FRAMES  = 4;
    localparam int DEF_T_BL_LVDS  = 1_000_000;
    localparam int DEF_T_LVDS_VDD = 500_000;
    localparam int DEF_T_OFF_MIN  = 50_000_000;
    localparam int DEF_CNT_W      = 28;
    localparam int DEF_PWM_W      = 8;

    typedef struct packed {
        logic vdd_en;
        logic lvds_resetn;
        logic bl_en;
        logic ready;
    } rail_t;

    function automatic rail_t decode_rails(seq_state_t s);
        rail_t r;
        r.vdd_en      = s inside {ST_VDD_UP, ST_LVDS_UP, ST_ON, ST_BL_DOWN, ST_LVDS_DOWN};
        r.lvds_resetn = s inside {ST_LVDS_UP, ST_ON, ST_BL_DOWN};
        r.bl_en       = (s == ST_ON);
        r.ready       = (s == ST_ON);
        return r;
    endfunction

endpackage

// File: rtl/lvds_panel_seq_bl_pwm_gen.sv
// Backlight PWM: free-running counter, duty latched at the period boundary,
// registered compare gated by the backlight enable.
module lvds_panel_seq_bl_pwm_gen #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             bl_en,
    input  logic [PWM_W-1:0] brightness,
    output logic             pwm
);

    localparam logic [PWM_W-1:0] ALL_ONES = '1;

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would chain cnt into the compare.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt  <= '0;
            duty <= '0;
            pwm  <= 1'b0;
        end else begin
            cnt <= cnt + PWM_W'(1);
            // Duty only changes at the wrap so a period is never cut short
            if (cnt == ALL_ONES) begin
                duty <= brightness;
            end
            pwm <= bl_en & ((duty == ALL_ONES) | (cnt < duty));
        end
    end

endmodule

// File: rtl/lvds_panel_seq.sv
// Panel VDD / LVDS reset / backlight power sequencer with enforced off-time;
// outputs are registered from the next state so they align with o_state.
module lvds_panel_seq
    import lvds_panel_seq_pkg::*;
#(
    parameter int T_VDD_LVDS = DEF_T_VDD_LVDS,
    parameter int BL_FRAMES  = DEF_BL_FRAMES,
    parameter int T_BL_LVDS  = DEF_T_BL_LVDS,
    parameter int T_LVDS_VDD = DEF_T_LVDS_VDD,
    parameter int T_OFF_MIN  = DEF_T_OFF_MIN,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int PWM_W      = DEF_PWM_W
) (
    input  logic             i_clk,
    input  logic             i_resetn,
    input  logic             i_enable,
    input  logic             i_fault,
    input  logic             i_frame_start,
    input  logic [PWM_W-1:0] i_brightness,
    output logic             o_vdd_en,
    output logic             o_lvds_resetn,
    output logic             o_bl_en,
    output logic             o_bl_pwm,
    output logic             o_ready,
    output logic [2:0]       o_state
);

    localparam int FRM_W = (BL_FRAMES > 1) ? $clog2(BL_FRAMES) : 1;
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BL_FRAMES - 1);

    localparam logic [CNT_W-1:0] LD_VDD_LVDS = CNT_W'(T_VDD_LVDS - 1);
    localparam logic [CNT_W-1:0] LD_BL_LVDS  = CNT_W'(T_BL_LVDS - 1);
    localparam logic [CNT_W-1:0] LD_LVDS_VDD = CNT_W'(T_LVDS_VDD - 1);
    localparam logic [CNT_W-1:0] LD_OFF_MIN  = CNT_W'(T_OFF_MIN - 1);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [CNT_W-1:0] dly_cnt;
    logic [CNT_W-1:0] dly_load;
    logic [FRM_W-1:0] frm_cnt;
    logic             entry;
    logic             expired;
    logic             abort;
    logic             frame_hit;
    rail_t            rail_next;

    assign expired   = (dly_cnt == '0);
    assign abort     = ~i_enable | i_fault;
    // A frame pulse in the first cycle of LVDS_UP may belong to a stream
    // that was not yet valid, so it is not counted.
    assign frame_hit = i_frame_start & ~entry;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            state         <= ST_OFF_WAIT;
            dly_cnt       <= LD_OFF_MIN;
            frm_cnt       <= '0;
            entry         <= 1'b1;
            o_vdd_en      <= 1'b0;
            o_lvds_resetn <= 1'b0;
            o_bl_en       <= 1'b0;
            o_ready       <= 1'b0;
        end else begin
            state <= state_next;
            entry <= (state_next != state);

            if (state_next != state) begin
                dly_cnt <= dly_load;
            end else if (!expired) begin
                dly_cnt <= dly_cnt - CNT_W'(1);
            end

            if (state_next != state) begin
                frm_cnt <= '0;
            end else if (state == ST_LVDS_UP && frame_hit) begin
                frm_cnt <= frm_cnt + FRM_W'(1);
            end

            o_vdd_en      <= rail_next.vdd_en;
            o_lvds_resetn <= rail_next.lvds_resetn;
            o_bl_en       <= rail_next.bl_en;
            o_ready       <= rail_next.ready;
        end
    end

    // Aborts are tested before expiry/frame conditions so they always win.
    // NOTE: state_next and dly_load get defaults first, so no path through
    // the case can leave them unassigned and infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_OFF_WAIT:  if (expired) state_next = ST_OFF;
            ST_OFF:       if (i_enable && !i_fault) state_next = ST_VDD_UP;
            ST_VDD_UP: begin
                if (abort)        state_next = ST_LVDS_DOWN;
                else if (expired) state_next = ST_LVDS_UP;
            end
            ST_LVDS_UP: begin
                if (abort)                                state_next = ST_LVDS_DOWN;
                else if (frame_hit && frm_cnt == FRM_LAST) state_next = ST_ON;
            end
            ST_ON:        if (abort) state_next = ST_BL_DOWN;
            ST_BL_DOWN:   if (expired) state_next = ST_LVDS_DOWN;
            ST_LVDS_DOWN: if (expired) state_next = ST_OFF_WAIT;
            default:      state_next = ST_OFF_WAIT;
        endcase

        dly_load = '0;
        case (state_next)
            ST_VDD_UP:    dly_load = LD_VDD_LVDS;
            ST_BL_DOWN:   dly_load = LD_BL_LVDS;
            ST_LVDS_DOWN: dly_load = LD_LVDS_VDD;
            ST_OFF_WAIT:  dly_load = LD_OFF_MIN;
            default:      dly_load = '0;
        endcase
    end

    always_comb begin
        rail_next = decode_rails(state_next);
    end

    assign o_state = state;

    lvds_panel_seq_bl_pwm_gen #(
        .PWM_W(PWM_W)
    ) u_bl_pwm (
        .clk        (i_clk),
        .resetn     (i_resetn),
        .bl_en      (rail_next.bl_en),
        .brightness (i_brightness),
        .pwm        (o_bl_pwm)
    );

endmodule

// File: tb/tb_lvds_panel_seq.sv
// Scoreboard bench: stimulus predicts output-change events and PWM duty counts
// from the timing rules; monitors compare whenever the outputs move.
module tb_lvds_panel_seq;

    localparam int T_VDD_LVDS = 10;
    localparam int BL_FRAMES  = 2;
    localparam int T_BL_LVDS  = 8;
    localparam int T_LVDS_VDD = 5;
    localparam int T_OFF_MIN  = 20;
    localparam int PWM_W      = 4;
    localparam int PERIOD     = 1 << PWM_W;

    localparam int S_OFF_WAIT = 0, S_OFF = 1, S_VDD_UP = 2, S_LVDS_UP = 3;
    localparam int S_ON = 4, S_BL_DOWN = 5, S_LVDS_DOWN = 6;

    logic             clk = 1'b0;
    logic             resetn, enable, fault, frame_start;
    logic [PWM_W-1:0] brightness;
    logic             vdd_en, lvds_resetn, bl_en, bl_pwm, ready;
    logic [2:0]       state;

    lvds_panel_seq #(
        .T_VDD_LVDS(T_VDD_LVDS), .BL_FRAMES(BL_FRAMES), .T_BL_LVDS(T_BL_LVDS),
        .T_LVDS_VDD(T_LVDS_VDD), .T_OFF_MIN(T_OFF_MIN), .CNT_W(28), .PWM_W(PWM_W)
    ) dut (
        .i_clk(clk), .i_resetn(resetn), .i_enable(enable), .i_fault(fault),
        .i_frame_start(frame_start), .i_brightness(brightness),
        .o_vdd_en(vdd_en), .o_lvds_resetn(lvds_resetn), .o_bl_en(bl_en),
        .o_bl_pwm(bl_pwm), .o_ready(ready), .o_state(state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int at; logic [6:0] vec; } ev_t;
    typedef struct { int start; int ones; } pw_t;
    ev_t ev_q[$];
    pw_t pw_q[$];

    int tests = 0;
    int fails = 0;
    int dark_viol = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected {state, vdd_en, lvds_resetn, bl_en, ready} for a state number
    function automatic logic [6:0] vec_of(input int st);
        logic v, l, b;
        v = (st >= S_VDD_UP) && (st <= S_LVDS_DOWN);
        l = (st >= S_LVDS_UP) && (st <= S_BL_DOWN);
        b = (st == S_ON);
        return {3'(st), v, l, b, b};
    endfunction

    task automatic push_ev(input int at, input int st);
        ev_t e;
        e.at  = at;
        e.vec = vec_of(st);
        ev_q.push_back(e);
    endtask

    task automatic push_pw(input int start, input int duty);
        pw_t p;
        p.start = start;
        p.ones  = (duty == PERIOD - 1) ? PERIOD : duty;
        pw_q.push_back(p);
    endtask

    task automatic goto_cyc(input int e);
        while (cyc < e) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Frame pulse sampled by the DUT at edge e
    task automatic pulse_at(input int e);
        goto_cyc(e - 1);
        frame_start = 1'b1;
        goto_cyc(e);
        frame_start = 1'b0;
    endtask

    // Output window c..c+PERIOD-1 uses the duty latched at edge c-1
    function automatic int next_align(input int from, input int rel);
        int c;
        c = from;
        while (((c - 1 - rel) % PERIOD) != 0) c++;
        return c;
    endfunction

    // Monitor: every change of the sequencing outputs consumes one expected event
    initial begin
        logic [6:0] prev, cur;
        ev_t e;
        int  pw_ones;
        pw_ones = 0;
        @(posedge clk);
        @(negedge clk);
        prev = {state, vdd_en, lvds_resetn, bl_en, ready};
        forever begin
            @(negedge clk);
            cur = {state, vdd_en, lvds_resetn, bl_en, ready};
            if (cur !== prev) begin
                if (ev_q.size() == 0) begin
                    check("unexpected_change", 32'(cur), 32'(prev));
                end else begin
                    e = ev_q.pop_front();
                    check("event_outputs", 32'(cur), 32'(e.vec));
                    check("event_cycle", cyc, e.at);
                end
            end
            prev = cur;
            if (bl_pwm !== 1'b0 && bl_en !== 1'b1) dark_viol++;
            if (pw_q.size() > 0 && cyc >= pw_q[0].start && cyc < pw_q[0].start + PERIOD) begin
                pw_ones += (bl_pwm === 1'b1) ? 1 : 0;
                if (cyc == pw_q[0].start + PERIOD - 1) begin
                    check("pwm_high_cycles", pw_ones, pw_q[0].ones);
                    pw_ones = 0;
                    void'(pw_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, lup, p1, p2, c0, rnd, d, f, lup2, p3, p4, g, r2;
        resetn      = 1'b0;
        enable      = 1'b1;
        fault       = 1'b0;
        frame_start = 1'b0;
        brightness  = '0;

        goto_cyc(3);
        check("reset_state", 32'(state), S_OFF_WAIT);
        check("reset_vdd", 32'(vdd_en), 0);
        check("reset_lvds", 32'(lvds_resetn), 0);
        check("reset_bl", 32'(bl_en), 0);
        check("reset_pwm", 32'(bl_pwm), 0);
        check("reset_ready", 32'(ready), 0);

        // Power-up: off-time served first, then VDD, then LVDS after T2
        resetn = 1'b1;
        r0  = 3;
        lup = r0 + T_OFF_MIN + 1 + T_VDD_LVDS;
        push_ev(r0 + T_OFF_MIN, S_OFF);
        push_ev(r0 + T_OFF_MIN + 1, S_VDD_UP);
        push_ev(lup, S_LVDS_UP);

        // Entry-cycle pulse ignored; ON follows the BL_FRAMES-th counted pulse
        p1 = lup + 1 + $urandom_range(2, 40);
        p2 = p1 + $urandom_range(60, 120);
        push_ev(p2, S_ON);
        pulse_at(lup + 1);
        pulse_at(p1);
        pulse_at(p2);

        // Brightness changes mid-period only land at the next period boundary
        rnd = $urandom_range(1, PERIOD - 2);
        c0  = next_align(cyc + 3, r0);
        goto_cyc(c0 - 2);
        brightness = 4'd4;
        push_pw(c0, 4);
        goto_cyc(c0 + 5);
        brightness = 4'd0;
        push_pw(c0 + PERIOD, 0);
        goto_cyc(c0 + PERIOD + 5);
        brightness = 4'd15;
        push_pw(c0 + 2 * PERIOD, PERIOD - 1);
        goto_cyc(c0 + 2 * PERIOD + 5);
        brightness = PWM_W'(rnd);
        push_pw(c0 + 3 * PERIOD, rnd);

        // Enable drop in ON: reverse order, immediate re-enable must wait out T7
        d = c0 + 4 * PERIOD + $urandom_range(1, 10);
        push_ev(d, S_BL_DOWN);
        push_ev(d + T_BL_LVDS, S_LVDS_DOWN);
        push_ev(d + T_BL_LVDS + T_LVDS_VDD, S_OFF_WAIT);
        push_ev(d + T_BL_LVDS + T_LVDS_VDD + T_OFF_MIN, S_OFF);
        push_ev(d + T_BL_LVDS + T_LVDS_VDD + T_OFF_MIN + 1, S_VDD_UP);
        goto_cyc(d - 1);
        enable = 1'b0;
        goto_cyc(d);
        enable = 1'b1;

        // Fault in VDD_UP (possibly in its expiry cycle): straight to LVDS_DOWN
        f = d + T_BL_LVDS + T_LVDS_VDD + T_OFF_MIN + 1 + $urandom_range(1, T_VDD_LVDS);
        push_ev(f, S_LVDS_DOWN);
        push_ev(f + T_LVDS_VDD, S_OFF_WAIT);
        push_ev(f + T_LVDS_VDD + T_OFF_MIN, S_OFF);
        push_ev(f + T_LVDS_VDD + T_OFF_MIN + 1, S_VDD_UP);
        lup2 = f + T_LVDS_VDD + T_OFF_MIN + 1 + T_VDD_LVDS;
        push_ev(lup2, S_LVDS_UP);
        goto_cyc(f - 1);
        fault = 1'b1;
        goto_cyc(f);
        fault = 1'b0;

        p3 = lup2 + 1 + $urandom_range(2, 20);
        p4 = p3 + $urandom_range(2, 20);
        push_ev(p4, S_ON);
        pulse_at(lup2 + 1);
        pulse_at(p3);
        pulse_at(p4);

        // Reset mid-ON clears everything on the next edge
        g = p4 + $urandom_range(3, 15);
        push_ev(g, S_OFF_WAIT);
        goto_cyc(g - 1);
        resetn = 1'b0;
        goto_cyc(g);
        check("midreset_pwm", 32'(bl_pwm), 0);
        check("midreset_state", 32'(state), S_OFF_WAIT);
        goto_cyc(g + 2);
        resetn = 1'b1;
        r2 = g + 2;
        push_ev(r2 + T_OFF_MIN, S_OFF);
        push_ev(r2 + T_OFF_MIN + 1, S_VDD_UP);

        goto_cyc(r2 + T_OFF_MIN + 5);
        check("events_outstanding", 32'(ev_q.size()), 0);
        check("pwm_windows_outstanding", 32'(pw_q.size()), 0);
        check("pwm_without_backlight", 32'(dark_viol), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lvds_panel_seq.md
Name: lvds_panel_seq

Overview:
- Power/enable sequencer for the LVDS panel (LP171WU3 class) and the LVDS serializer/timing path.
- Order on power-up: panel VDD, then the LVDS stream (serializer reset released), then the backlight after N whole frames.
- Power-down runs in reverse order, and a minimum off-time is enforced before the next power-up.
- Also generates the backlight PWM. Sits between top-level control (enable/brightness/fault) and the LVDS module's reset input.

Parameters:
- T_VDD_LVDS, 1_000_000, cycles from VDD on to LVDS reset release (T2)
- BL_FRAMES, 4, whole frames of valid LVDS before backlight on (T3)
- T_BL_LVDS, 1_000_000, cycles from backlight off to LVDS reset assert (T4)
- T_LVDS_VDD, 500_000, cycles from LVDS reset assert to VDD off (T5)
- T_OFF_MIN, 50_000_000, minimum cycles VDD stays off before re-power (T7)
- CNT_W, 28, width of the delay down-counter; each T_* must fit in it
- PWM_W, 8, PWM resolution in bits

Ports:
- i_clk  in  1  system clock
- i_resetn  in  1  synchronous, active-low reset
- i_enable  in  1  level; 1 = panel requested on
- i_fault  in  1  level; 1 forces shutdown, and the block stays down while asserted
- i_frame_start  in  1  one-cycle pulse per frame from the timing generator (v_current wrap), synchronous to i_clk
- i_brightness  in  PWM_W  backlight duty
- o_vdd_en  out  1  panel VDD switch enable
- o_lvds_resetn  out  1  drives the LVDS serializer/timing reset (active-low)
- o_bl_en  out  1  backlight enable
- o_bl_pwm  out  1  backlight PWM
- o_ready  out  1  1 only in state ON
- o_state  out  3  current state encoding

Behaviour:
- Reset: state OFF_WAIT, delay counter = T_OFF_MIN-1. All outputs 0 except o_state=OFF_WAIT; the PWM counter and latched duty are also 0. Reset asserted mid-sequence drops every output to 0 on the next edge.
- Outputs are registered and decoded from the state:
  - vdd_en=1 in VDD_UP, LVDS_UP, ON, BL_DOWN, LVDS_DOWN
  - lvds_resetn=1 in LVDS_UP, ON, BL_DOWN
  - bl_en=1 in ON only
- Delay counter: loaded with T-1 on state entry, decrements each cycle; "expired" = counter==0. A state with delay T therefore lasts exactly T cycles.
- States and transitions:
  - OFF_WAIT (0): on expiry → OFF.
  - OFF (1): i_enable & ~i_fault → VDD_UP (load T_VDD_LVDS-1).
  - VDD_UP (2): on expiry → LVDS_UP (frame counter cleared). ~i_enable | i_fault → LVDS_DOWN (load T_LVDS_VDD-1).
  - LVDS_UP (3): counts i_frame_start pulses and ignores a pulse in the entry cycle. When the count reaches BL_FRAMES → ON. ~i_enable | i_fault → LVDS_DOWN.
  - ON (4): ~i_enable | i_fault → BL_DOWN (load T_BL_LVDS-1).
  - BL_DOWN (5): on expiry → LVDS_DOWN. i_enable does not abort power-down.
  - LVDS_DOWN (6): on expiry → OFF_WAIT (load T_OFF_MIN-1).
- Priority: i_fault and ~i_enable are checked before the expiry/frame condition in the same cycle. If the abort and the advance condition coincide, the abort wins.
- Re-enable is honoured only from OFF, so the full off-time is always served.
- PWM:
  - Free-running PWM_W-bit counter; it wraps from all-ones to 0.
  - i_brightness is latched into the duty register when the counter is all-ones, so no mid-period glitch.
  - o_bl_pwm (registered) = bl_en & (duty == all-ones | cnt < duty).
  - Duty 0 gives constant 0; duty all-ones gives constant 1.
  - o_bl_pwm is 0 in the first cycle of every state other than ON.

Decomposition:
- Shared package holds:
  - state enum/localparams (OFF_WAIT..LVDS_DOWN, 3-bit)
  - default timing constants for LP171WU3
  - PWM_W
- Natural sub-module: bl_pwm_gen (counter, duty latch, compare).
- Sequencer FSM, delay counter and frame counter stay in lvds_panel_seq.

Test Plan (bench overrides: T_VDD_LVDS=10, BL_FRAMES=2, T_BL_LVDS=8, T_LVDS_VDD=5, T_OFF_MIN=20, PWM_W=4):
- Release reset with i_enable=1 → OFF_WAIT for 20 cycles, then OFF, VDD_UP; o_vdd_en rises.
- Continuing the power-up → o_lvds_resetn rises exactly 10 cycles after o_vdd_en.
- Two i_frame_start pulses in LVDS_UP, 100 cycles apart → o_bl_en and o_ready rise the cycle after the second pulse. A pulse in the LVDS_UP entry cycle does not count.
- Brightness sweep in ON, i_brightness=4 then 0 then 15 → PWM high 4 of 16 cycles, then constant 0, then constant 1. Changes take effect only at the next period boundary.
- Drop i_enable in ON → o_bl_en falls, then o_lvds_resetn falls 8 cycles later, then o_vdd_en falls 5 cycles after that. Re-raising i_enable immediately leaves o_vdd_en low for ≥20 cycles.
- Cases: i_fault pulse during VDD_UP; i_resetn low mid-ON.
  - i_fault in VDD_UP → LVDS_DOWN directly; o_lvds_resetn never rises.
  - i_resetn low in ON → all outputs 0 on the next edge, o_state=0.
